// File: rtl/skip_pkg.sv
// Shared types and helpers for the skip-mask receiver.
// State encoding, default frame length, count width.
package skip_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    ACQ,
    LOCK
  } state_t;

  localparam int LEN_DEF = 16;

  function automatic int cw_of(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/skipmask_rx_if.sv
// Output bus of the skip-mask receiver.
// Mask publish with valid/ready plus lock/error status.
interface skipmask_rx_if
  import skip_pkg::*;
#(
  parameter int LEN = LEN_DEF
) ();

  localparam int CW = cw_of(LEN);

  logic [LEN-1:0] oMASK;
  logic           oVALID;
  logic           iREADY;
  logic [CW-1:0]  oSKIPS;
  logic           oLOCK;
  logic           oERR;

  modport master (
    output oMASK,
    output oVALID,
    input  iREADY,
    output oSKIPS,
    output oLOCK,
    output oERR
  );

  modport slave (
    input  oMASK,
    input  oVALID,
    output iREADY,
    input  oSKIPS,
    input  oLOCK,
    input  oERR
  );

endinterface

// File: rtl/skip_popcnt.sv
// Combinational popcount of a LEN-bit word.
// Feeds the registered skip count.
module skip_popcnt
  import skip_pkg::*;
#(
  parameter int LEN = LEN_DEF,
  parameter int CW  = cw_of(LEN)
) (
  input  logic [LEN-1:0] d,
  output logic [CW-1:0]  cnt
);

  // sum the set bits
  always_comb begin
    cnt = '0;
    for (int i = 0; i < LEN; i++) begin
      cnt = cnt + CW'(d[i]);
    end
  end

endmodule

// File: rtl/skipmask_rx.sv
// Recovers the skip mask from the ring's slot stream.
// Qualifies it over identical frames, publishes via valid/ready.
module skipmask_rx
  import skip_pkg::*;
#(
  parameter int LEN     = LEN_DEF,
  parameter int LOCKCNT = 3,
  parameter int CW      = cw_of(LEN)
) (
  input  logic iCLK,
  input  logic nRST,
  input  logic E,
  input  logic iB0,
  input  logic iP,
  skipmask_rx_if.master bus
);

  localparam int IW = $clog2(LEN);
  localparam int MW = $clog2(LOCKCNT + 2);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  localparam logic [MW-1:0] MLK  = MW'(LOCKCNT);

  state_t         st, st_n;
  logic [IW-1:0]  idx, idx_n;
  logic [LEN-1:0] cap, cap_n;
  logic [LEN-1:0] prev, prev_n;
  logic [LEN-1:0] cand;
  logic [MW-1:0]  m, m_n, mi;
  logic           pub, drop, err_n;
  logic [CW-1:0]  pc;

  logic [LEN-1:0] mask_q;
  logic [CW-1:0]  skips_q;
  logic           valid_q, lock_q, err_q;

  assign bus.oMASK  = mask_q;
  assign bus.oSKIPS = skips_q;
  assign bus.oVALID = valid_q;
  assign bus.oLOCK  = lock_q;
  assign bus.oERR   = err_q;

  // candidate frame: capture with the current slot merged in
  always_comb begin
    cand      = cap;
    cand[idx] = ~iP;
  end

  skip_popcnt #(
    .LEN (LEN),
    .CW  (CW)
  ) u_pc (
    .d   (cand),
    .cnt (pc)
  );

  // next state: capture, framing checks, qualification
  always_comb begin
    st_n   = st;
    idx_n  = idx;
    cap_n  = cap;
    prev_n = prev;
    m_n    = m;
    mi     = m;
    pub    = 1'b0;
    drop   = 1'b0;
    err_n  = 1'b0;
    if (E) begin
      unique case (st)
        SEARCH: begin
          if (iB0) begin
            cap_n[0] = ~iP;
            idx_n    = IW'(1);
            m_n      = '0;
            st_n     = ACQ;
          end
        end
        default: begin
          if (iB0 && idx != '0) begin
            err_n    = 1'b1;
            drop     = 1'b1;
            m_n      = '0;
            cap_n[0] = ~iP;
            idx_n    = IW'(1);
            st_n     = ACQ;
          end else if (!iB0 && idx == '0) begin
            err_n = 1'b1;
            drop  = 1'b1;
            cap_n = '0;
            st_n  = SEARCH;
          end else begin
            cap_n = cand;
            idx_n = (idx == LAST) ? '0 : idx + IW'(1);
            if (idx == LAST) begin
              if (st == ACQ) begin
                if (m == '0 || cand != prev) begin
                  prev_n = cand;
                  mi     = MW'(1);
                end else begin
                  mi = m + MW'(1);
                end
                m_n = mi;
                if (mi >= MLK) begin
                  pub  = 1'b1;
                  st_n = LOCK;
                end
              end else if (cand != mask_q) begin
                err_n  = 1'b1;
                drop   = 1'b1;
                prev_n = cand;
                m_n    = MW'(1);
                st_n   = ACQ;
              end
            end
          end
        end
      endcase
    end
  end

  // receiver state registers
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      st   <= SEARCH;
      idx  <= '0;
      cap  <= '0;
      prev <= '0;
      m    <= '0;
    end else begin
      st   <= st_n;
      idx  <= idx_n;
      cap  <= cap_n;
      prev <= prev_n;
      m    <= m_n;
    end
  end

  // publish, handshake and status outputs
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      mask_q  <= '0;
      skips_q <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_n;
      if (pub) begin
        mask_q  <= cand;
        skips_q <= pc;
        valid_q <= 1'b1;
        lock_q  <= 1'b1;
      end else begin
        if (valid_q && bus.iREADY) valid_q <= 1'b0;
        if (drop) lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_skipmask_rx.sv
// Bench for skipmask_rx: directed frame scenarios with random masks,
// gaps and idle-cycle noise against a frame-level reference model.
module tb_skipmask_rx;

  localparam int LEN     = 16;
  localparam int LOCKCNT = 3;

  logic iCLK = 1'b0;
  logic nRST = 1'b0;
  logic E    = 1'b0;
  logic iB0  = 1'b0;
  logic iP   = 1'b0;

  skipmask_rx_if #(.LEN(LEN)) bus ();

  skipmask_rx #(
    .LEN     (LEN),
    .LOCKCNT (LOCKCNT)
  ) dut (
    .iCLK (iCLK),
    .nRST (nRST),
    .E    (E),
    .iB0  (iB0),
    .iP   (iP),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;
  bit rdy_v = 1'b1;
  bit rnd_rdy = 1'b0;

  // reference model: slot alignment plus a history of whole frames
  bit          m_align;
  int          m_pos;
  bit [LEN-1:0] m_cur;
  bit [LEN-1:0] m_q[$];
  bit          m_lock;
  bit [LEN-1:0] m_mask;
  bit          m_valid;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_align = 0;
    m_pos   = 0;
    m_cur   = '0;
    m_q.delete();
    m_lock  = 0;
    m_mask  = '0;
    m_valid = 0;
    m_err   = 0;
  endtask

  function automatic bit run_full();
    if (m_q.size() < LOCKCNT) return 0;
    for (int i = 1; i < m_q.size(); i++)
      if (m_q[i] != m_q[0]) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit e, input bit b0, input bit p,
                            input bit rdy);
    bit pub = 0;
    bit er = 0;
    bit [LEN-1:0] f;
    f = '0;
    if (e) begin
      if (!m_align) begin
        if (b0) begin
          m_align = 1;
          m_q.delete();
          m_cur = '0;
          m_cur[0] = !p;
          m_pos = 1;
        end
      end else if (b0 && m_pos != 0) begin
        er = 1;
        m_lock = 0;
        m_q.delete();
        m_cur[0] = !p;
        m_pos = 1;
      end else if (!b0 && m_pos == 0) begin
        er = 1;
        m_lock = 0;
        m_align = 0;
        m_q.delete();
      end else begin
        m_cur[m_pos] = !p;
        if (m_pos == LEN - 1) begin
          f = m_cur;
          m_pos = 0;
          m_q.push_back(f);
          if (m_q.size() > LOCKCNT) void'(m_q.pop_front());
          if (m_lock) begin
            if (f != m_mask) begin
              er = 1;
              m_lock = 0;
            end
          end else if (run_full()) begin
            pub = 1;
          end
        end else begin
          m_pos++;
        end
      end
    end
    if (pub) begin
      m_mask  = f;
      m_valid = 1;
      m_lock  = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_err = er;
  endtask

  task automatic check_all();
    chk("mask",  32'(bus.oMASK),  32'(m_mask));
    chk("skips", 32'(bus.oSKIPS), 32'($countones(m_mask)));
    chk("valid", 32'(bus.oVALID), 32'(m_valid));
    chk("lock",  32'(bus.oLOCK),  32'(m_lock));
    chk("err",   32'(bus.oERR),   32'(m_err));
  endtask

  task automatic cyc(input bit e, input bit b0, input bit p);
    @(negedge iCLK);
    check_all();
    if (rnd_rdy) rdy_v = 1'($urandom);
    E   = e;
    iB0 = b0;
    iP  = p;
    bus.iREADY = rdy_v;
    model_step(e, b0, p, rdy_v);
  endtask

  task automatic slot(input bit b0, input bit p, input int gap);
    for (int g = 1; g < gap; g++)
      cyc(1'b0, 1'($urandom), 1'($urandom));
    cyc(1'b1, b0, p);
  endtask

  task automatic frame_rng(input bit [LEN-1:0] mk, input int gap,
                           input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      slot(i == 0, !mk[i], gap);
  endtask

  task automatic frame(input bit [LEN-1:0] mk, input int gap);
    frame_rng(mk, gap, 0, LEN - 1);
  endtask

  task automatic probe();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  bit [LEN-1:0] ma, mb, mc;

  initial begin
    mreset();
    bus.iREADY = 1'b1;
    #2;
    chk("rst_mask",  32'(bus.oMASK),  32'h0);
    chk("rst_valid", 32'(bus.oVALID), 32'h0);
    chk("rst_lock",  32'(bus.oLOCK),  32'h0);
    chk("rst_err",   32'(bus.oERR),   32'h0);
    @(negedge iCLK);
    nRST = 1'b1;

    // basic lock
    repeat (3) frame(16'h0005, 2);
    probe();
    chk("basic_valid", 32'(bus.oVALID), 32'h1);
    chk("basic_lock",  32'(bus.oLOCK),  32'h1);
    chk("basic_mask",  32'(bus.oMASK),  32'h0005);
    chk("basic_skips", 32'(bus.oSKIPS), 32'd2);

    // mask change while locked
    frame(16'h8001, 2);
    probe();
    chk("chg_err",  32'(bus.oERR),  32'h1);
    chk("chg_lock", 32'(bus.oLOCK), 32'h0);
    repeat (2) frame(16'h8001, 2);
    probe();
    chk("chg_relock", 32'(bus.oLOCK), 32'h1);
    chk("chg_mask",   32'(bus.oMASK), 32'h8001);

    // short frame: iB0 at slot 9
    frame_rng(16'h8001, 2, 0, 8);
    frame_rng(16'h8001, 2, 0, 0);
    probe();
    chk("short_err",  32'(bus.oERR),  32'h1);
    chk("short_lock", 32'(bus.oLOCK), 32'h0);
    frame_rng(16'h8001, 2, 1, LEN - 1);
    repeat (2) frame(16'h8001, 2);
    probe();
    chk("short_relock", 32'(bus.oLOCK), 32'h1);

    // long frame: iB0 missing at the boundary
    slot(1'b0, 1'b1, 2);
    probe();
    chk("long_err",  32'(bus.oERR),  32'h1);
    chk("long_lock", 32'(bus.oLOCK), 32'h0);
    repeat (5) slot(1'b0, 1'($urandom), 2);
    probe();
    chk("long_ign", 32'(bus.oERR), 32'h0);
    ma = LEN'($urandom);
    repeat (3) frame(ma, $urandom_range(1, 3));
    probe();
    chk("long_relock", 32'(bus.oLOCK), 32'h1);
    chk("long_mask",   32'(bus.oMASK), 32'(ma));

    // handshake: two publishes with iREADY low
    rdy_v = 1'b0;
    ma = LEN'($urandom);
    mb = ma ^ (LEN'($urandom) | LEN'(1));
    mc = mb ^ LEN'(16'h0100);
    repeat (3) frame(ma, 2);
    probe();
    repeat (3) frame(mb, 2);
    probe();
    chk("hold_valid", 32'(bus.oVALID), 32'h1);
    chk("hold_mask",  32'(bus.oMASK),  32'(mb));
    repeat (2) frame(mc, 2);
    frame_rng(mc, 2, 0, LEN - 2);
    probe();
    rdy_v = 1'b1;
    cyc(1'b1, 1'b0, !mc[LEN-1]);
    probe();
    chk("same_valid", 32'(bus.oVALID), 32'h1);
    chk("same_mask",  32'(bus.oMASK),  32'(mc));
    probe();
    chk("next_valid", 32'(bus.oVALID), 32'h0);
    chk("next_mask",  32'(bus.oMASK),  32'(mc));

    // random soak: two candidate masks, random gaps and ready
    rnd_rdy = 1'b1;
    ma = LEN'($urandom);
    mb = LEN'($urandom);
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 5) == 0)
        frame_rng(ma, 1, 0, $urandom_range(1, LEN - 2));
      else
        frame($urandom_range(0, 3) == 0 ? mb : ma,
              $urandom_range(1, 3));
    end
    probe();
    rnd_rdy = 1'b0;
    rdy_v = 1'b1;

    // asynchronous reset mid-frame
    frame_rng(ma, 2, 0, 6);
    #3;
    nRST = 1'b0;
    #1;
    chk("arst_mask",  32'(bus.oMASK),  32'h0);
    chk("arst_skips", 32'(bus.oSKIPS), 32'h0);
    chk("arst_valid", 32'(bus.oVALID), 32'h0);
    chk("arst_lock",  32'(bus.oLOCK),  32'h0);
    chk("arst_err",   32'(bus.oERR),   32'h0);
    mreset();
    E = 1'b0;
    repeat (2) @(negedge iCLK);
    nRST = 1'b1;
    for (int k = 0; k < 3 * LEN; k++) cyc(1'b1, 1'b0, 1'($urandom));
    probe();
    chk("nob0_lock",  32'(bus.oLOCK),  32'h0);
    chk("nob0_valid", 32'(bus.oVALID), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
